branch_unit: RTL and testbench

Parametrised next-generation program-counter block for the RISC machine CPU. It replaces the inline next-PC mux and the 9-bit PC register, and adds:
- the full condition set applied uniformly to branch, call and return;
- a hardware return-address stack of configurable depth, so subroutine call/return needs no register-file link traffic;
- sticky overflow/underflow error flags.

It sits between the FSM controller (load strobe, command), the instruction decoder (cond, sximm8), the datapath status flags, and the memory address mux, which consumes `PC`.

---
 rtl/branch_unit.sv | 151 +++++++++++++++
 tb/tb_branch_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// branch_unit: program counter with conditional branch/call/return and a
// circular hardware return-address stack with sticky overflow/underflow flags.
module branch_unit #(
  parameter int unsigned pc_width     = 9,
  parameter int unsigned data_width   = 16,
  parameter int unsigned stack_depth  = 4,
  parameter int unsigned reset_vector = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load_pc,
  input  logic [1:0]                         br_cmd,
  input  logic [2:0]                         cond,
  input  logic [data_width-1:0]              sximm8,
  input  logic                               Z,
  input  logic                               N,
  input  logic                               V,
  input  logic                               clear_err,
  output logic [pc_width-1:0]                PC,
  output logic [pc_width-1:0]                link,
  output logic [$clog2(stack_depth+1)-1:0]   depth,
  output logic                               taken,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int unsigned CNT_W = $clog2(stack_depth + 1);
  localparam int unsigned PTR_W = (stack_depth > 1) ? $clog2(stack_depth) : 1;

  localparam logic [1:0] CMD_BRANCH = 2'b01;
  localparam logic [1:0] CMD_CALL   = 2'b10;
  localparam logic [1:0] CMD_RETURN = 2'b11;

  logic [pc_width-1:0] pc_q, pc_d;
  logic                taken_q, taken_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [PTR_W-1:0]    wptr_q, wptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [pc_width-1:0] mem_q [stack_depth];

  logic [pc_width-1:0] seq, tgt;
  logic [PTR_W-1:0]    top_idx, next_idx;
  logic                cond_ok, full, push;

  // Only the low pc_width bits of the offset matter; the rest are intentionally dropped.
  if (data_width > pc_width) begin : g_unused_hi
    logic unused_sximm8_hi;
    assign unused_sximm8_hi = ^sximm8[data_width-1:pc_width];
  end

  // Condition evaluation from the datapath status flags.
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      3'b000:  cond_ok = 1'b1;
      3'b001:  cond_ok = Z;
      3'b010:  cond_ok = ~Z;
      3'b011:  cond_ok = N ^ V;
      3'b100:  cond_ok = (N ^ V) | Z;
      default: cond_ok = 1'b0;
    endcase
  end

  // Address arithmetic and circular-buffer pointer neighbours.
  always_comb begin
    seq      = pc_q + pc_width'(1);
    tgt      = seq + sximm8[pc_width-1:0];
    top_idx  = (wptr_q == '0) ? PTR_W'(stack_depth - 1) : wptr_q - PTR_W'(1);
    next_idx = (wptr_q == PTR_W'(stack_depth - 1)) ? '0 : wptr_q + PTR_W'(1);
    full     = (cnt_q == CNT_W'(stack_depth));
  end

  // Next-state computation for PC, stack pointers and error flags.
  always_comb begin
    pc_d    = pc_q;
    taken_d = taken_q;
    ovf_d   = ovf_q & ~clear_err;
    unf_d   = unf_q & ~clear_err;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (load_pc) begin
      pc_d    = seq;
      taken_d = 1'b0;
      case (br_cmd)
        CMD_BRANCH: begin
          if (cond_ok) begin
            pc_d    = tgt;
            taken_d = 1'b1;
          end
        end
        CMD_CALL: begin
          if (cond_ok) begin
            pc_d    = tgt;
            taken_d = 1'b1;
            push    = 1'b1;
            wptr_d  = next_idx;
            if (full) ovf_d = 1'b1;
            else      cnt_d = cnt_q + CNT_W'(1);
          end
        end
        CMD_RETURN: begin
          if (cond_ok) begin
            if (cnt_q != '0) begin
              pc_d    = mem_q[top_idx];
              taken_d = 1'b1;
              wptr_d  = top_idx;
              cnt_d   = cnt_q - CNT_W'(1);
            end else begin
              unf_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State register with synchronous reset taking priority over any update.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= pc_width'(reset_vector);
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      wptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Return-address storage; contents are hidden by the count so need no reset.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wptr_q] <= seq;
  end

  assign PC        = pc_q;
  assign taken     = taken_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign depth     = cnt_q;
  assign link      = (cnt_q == '0) ? '0 : mem_q[top_idx];

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the PC and return stack.
module tb_branch_unit;

  localparam int PCM   = 512;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, load_pc, Z, N, V, clear_err;
  logic [1:0]  br_cmd;
  logic [2:0]  cond;
  logic [15:0] sximm8;
  logic [8:0]  PC, link;
  logic [2:0]  depth;
  logic        taken, overflow, underflow;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int m_pc;
  int m_stack[$];
  bit m_taken, m_ovf, m_unf;

  branch_unit #(.pc_width(9), .data_width(16), .stack_depth(DEPTH), .reset_vector(0)) dut (
    .clk(clk), .reset(reset), .load_pc(load_pc), .br_cmd(br_cmd), .cond(cond),
    .sximm8(sximm8), .Z(Z), .N(N), .V(V), .clear_err(clear_err),
    .PC(PC), .link(link), .depth(depth), .taken(taken),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === 32'(exp)) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit cond_true(input int c, input bit z, input bit n, input bit v);
    case (c)
      0: return 1'b1;
      1: return z;
      2: return !z;
      3: return n != v;
      4: return (n != v) || z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model(input bit rst, input bit ld, input int cmd, input int c,
                       input int off, input bit z, input bit n, input bit v, input bit clr);
    int seq, tgt;
    bit ok;
    if (rst) begin
      m_pc = 0; m_stack.delete(); m_taken = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    if (clr) begin m_ovf = 0; m_unf = 0; end
    if (!ld) return;
    seq = (m_pc + 1) % PCM;
    tgt = (m_pc + 1 + (off % PCM)) % PCM;
    ok  = cond_true(c, z, n, v);
    m_pc = seq; m_taken = 0;
    if (cmd == 1 && ok) begin
      m_pc = tgt; m_taken = 1;
    end else if (cmd == 2 && ok) begin
      m_stack.push_back(seq);
      if (m_stack.size() > DEPTH) begin void'(m_stack.pop_front()); m_ovf = 1; end
      m_pc = tgt; m_taken = 1;
    end else if (cmd == 3 && ok) begin
      if (m_stack.size() > 0) begin m_pc = m_stack.pop_back(); m_taken = 1; end
      else m_unf = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    32'(PC),        m_pc);
    chk({tag, ".taken"}, 32'(taken),     int'(m_taken));
    chk({tag, ".depth"}, 32'(depth),     m_stack.size());
    chk({tag, ".link"},  32'(link),      (m_stack.size() > 0) ? m_stack[$] : 0);
    chk({tag, ".ovf"},   32'(overflow),  int'(m_ovf));
    chk({tag, ".unf"},   32'(underflow), int'(m_unf));
  endtask

  task automatic step(input string tag, input bit rst, input bit ld, input int cmd, input int c,
                      input int off, input bit z, input bit n, input bit v, input bit clr);
    reset = rst; load_pc = ld; br_cmd = 2'(cmd); cond = 3'(c); sximm8 = 16'(off);
    Z = z; N = n; V = v; clear_err = clr;
    @(posedge clk);
    #1;
    model(rst, ld, cmd, c, off & 16'hFFFF, z, n, v, clr);
    check_all(tag);
  endtask

  // Unconditional branch landing on an absolute address.
  task automatic goto(input int target);
    step("goto", 0, 1, 1, 0, (target - m_pc - 1 + PCM) % PCM, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; load_pc = 0; br_cmd = 0; cond = 0; sximm8 = 0;
    Z = 0; N = 0; V = 0; clear_err = 0;
    m_pc = 0; m_taken = 0; m_ovf = 0; m_unf = 0;

    // Reset and sequential fetch.
    step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset.pc_const", 32'(PC), 0);
    for (int i = 0; i < 3; i++) step("seq", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("seq.pc_const", 32'(PC), 3);

    // Conditional branches.
    goto(5);
    step("beq", 0, 1, 1, 1, 4, 1, 0, 0, 0);
    chk("beq.pc_const", 32'(PC), 10);
    step("blt", 0, 1, 1, 3, -3, 0, 1, 1, 0);
    chk("blt.pc_const", 32'(PC), 11);
    step("ble", 0, 1, 1, 4, 2, 1, 0, 0, 0);
    chk("ble.taken_const", 32'(taken), 1);
    step("rsv", 0, 1, 1, 5, 2, 1, 1, 0, 0);
    chk("rsv.taken_const", 32'(taken), 0);

    // Call/return nesting.
    goto(20);
    step("call1", 0, 1, 2, 0, 10, 0, 0, 0, 0);
    chk("call1.link_const", 32'(link), 21);
    step("call2", 0, 1, 2, 0, 5, 0, 0, 0, 0);
    chk("call2.pc_const", 32'(PC), 37);
    step("ret1", 0, 1, 3, 0, 0, 0, 0, 0, 0);
    step("ret2", 0, 1, 3, 0, 0, 0, 0, 0, 0);
    chk("ret2.pc_const", 32'(PC), 21);

    // Overflow: five calls into a four-deep stack, then drain.
    for (int i = 0; i < 5; i++) step("ovf_call", 0, 1, 2, 0, 3, 0, 0, 0, 0);
    chk("ovf.flag_const", 32'(overflow), 1);
    chk("ovf.depth_const", 32'(depth), 4);
    for (int i = 0; i < 4; i++) step("ovf_ret", 0, 1, 3, 0, 0, 0, 0, 0, 0);
    chk("drain.depth_const", 32'(depth), 0);

    // Underflow and error clearing.
    goto(7);
    step("unf", 0, 1, 3, 0, 0, 0, 0, 0, 0);
    chk("unf.pc_const", 32'(PC), 8);
    step("unf_clr", 0, 1, 3, 0, 0, 0, 0, 0, 1);
    chk("unf_clr.flag_const", 32'(underflow), 1);
    step("clr_only", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("clr_only.flag_const", 32'(underflow), 0);

    // Wrap-around and reset during a call.
    goto(511);
    step("wrap_seq", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_seq.pc_const", 32'(PC), 0);
    goto(510);
    step("wrap_br", 0, 1, 1, 0, 5, 0, 0, 0, 0);
    chk("wrap_br.pc_const", 32'(PC), 4);
    step("call_pre", 0, 1, 2, 0, 1, 0, 0, 0, 0);
    step("rst_call", 1, 1, 2, 0, 9, 0, 0, 0, 0);
    chk("rst_call.depth_const", 32'(depth), 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 7) != 0),
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 65535)),
           1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
